// File: rtl/sram_b_fifo_pkg.sv
// sram_b_fifo_pkg: shared sizes, types and pointer helper for the sram_b stream FIFO
package sram_b_fifo_pkg;
  localparam int FIFO_DEPTH = 64;
  localparam int FIFO_AW = 6;
  localparam int FIFO_DW = 8;
  localparam int OBUF_DEPTH = 2;
  localparam int CNT_W = 7;
  localparam logic [FIFO_DW-1:0] WEM_ALL = 8'hFF;
  typedef logic [FIFO_DW-1:0] data_t;
  typedef logic [FIFO_AW-1:0] addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0] ocnt_t;
  function automatic addr_t ptr_inc(input addr_t p);
    return p + 1'b1;
  endfunction
endpackage

// File: rtl/sram_b_fifo_obuf.sv
// sram_b_fifo_obuf: 2-entry output skid buffer with head, count, push and pop
module sram_b_fifo_obuf
  import sram_b_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  data_t push_data,
  input  logic  pop,
  output ocnt_t cnt,
  output data_t head
);
  data_t e0_q, e0_d, e1_q, e1_d;
  ocnt_t cnt_q, cnt_d;
  logic do_pop, full;
  always_comb begin
    full = cnt_q == ocnt_t'(OBUF_DEPTH);
    do_pop = pop && cnt_q != '0;
    cnt_d = cnt_q + ocnt_t'(push) - ocnt_t'(do_pop);
    e0_d = do_pop ? (full ? e1_q : (push ? push_data : e0_q)) : ((push && cnt_q == '0) ? push_data : e0_q);
    e1_d = (push && (do_pop ? full : cnt_q == 2'd1)) ? push_data : e1_q;
    cnt = cnt_q;
    head = e0_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
endmodule

// File: rtl/unisim_sram_b_6abits.sv
// unisim_sram_b_6abits: 64x8 1w:1r SRAM, masked write port 0, registered read port 1
module unisim_sram_b_6abits (
  input  logic       CLK,
  input  logic       CE0,
  input  logic       WE0,
  input  logic [7:0] WEM0,
  input  logic [5:0] A0,
  input  logic [7:0] D0,
  input  logic       CE1,
  input  logic [5:0] A1,
  output logic [7:0] Q1
);
  logic [7:0] mem_q [64];
  always_ff @(posedge CLK) begin
    if (CE0 && WE0) mem_q[A0] <= (mem_q[A0] & ~WEM0) | (D0 & WEM0);
    if (CE1) Q1 <= mem_q[A1];
    if (CE0 && WE0 && CE1) addr_conflict: assert (A0 != A1);
  end
endmodule

// File: rtl/sram_b_stream_fifo.sv
// sram_b_stream_fifo: 66-word byte FIFO over unisim_sram_b_6abits; define SRAM_B_FIFO_BYPASS_EN to let words skip an empty SRAM
module sram_b_stream_fifo
  import sram_b_fifo_pkg::*;
#(
  parameter int AFULL_THR = 56
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [6:0] count,
  output logic       almost_full
);
  addr_t wptr_q, wptr_d, rptr_q, rptr_d, a0, a1;
  cnt_t mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic inflight_q, inflight_d, almost_full_q, almost_full_d;
  logic accept, pop, byp, wr, issue, obuf_push, ce0, we0, ce1;
  ocnt_t obuf_cnt;
  data_t obuf_data, obuf_head, q1, wem0, d0;
  always_comb begin
    in_ready = !RST && mem_cnt_q < cnt_t'(FIFO_DEPTH);
    accept = in_valid && in_ready;
    out_valid = obuf_cnt != '0;
    out_data = obuf_head;
    pop = out_valid && out_ready;
`ifdef SRAM_B_FIFO_BYPASS_EN
    byp = accept && mem_cnt_q == '0 && !inflight_q && (obuf_cnt < ocnt_t'(OBUF_DEPTH) || pop);
`else
    byp = 1'b0;
`endif
    wr = accept && !byp;
    issue = mem_cnt_q != '0 && ({1'b0, obuf_cnt} + {2'b0, inflight_q}) < ({2'b0, pop} + 3'd2);
    wptr_d = wr ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = issue ? ptr_inc(rptr_q) : rptr_q;
    mem_cnt_d = mem_cnt_q + cnt_t'(wr) - cnt_t'(issue);
    inflight_d = issue;
    count_d = count_q + cnt_t'(accept) - cnt_t'(pop);
    almost_full_d = count_d >= cnt_t'(AFULL_THR);
    obuf_push = inflight_q || byp;
    obuf_data = inflight_q ? q1 : in_data;
    ce0 = wr;
    we0 = wr;
    wem0 = wr ? WEM_ALL : '0;
    a0 = wr ? wptr_q : '0;
    d0 = wr ? in_data : '0;
    ce1 = issue;
    a1 = issue ? rptr_q : '0;
    count = count_q;
    almost_full = almost_full_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_cnt_q <= '0;
      inflight_q <= 1'b0;
      count_q <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_cnt_q <= mem_cnt_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      almost_full_q <= almost_full_d;
    end
  end
  sram_b_fifo_obuf u_obuf (
    .clk       (CLK),
    .rst       (RST),
    .push      (obuf_push),
    .push_data (obuf_data),
    .pop       (pop),
    .cnt       (obuf_cnt),
    .head      (obuf_head)
  );
  unisim_sram_b_6abits u_sram (
    .CLK  (CLK),
    .CE0  (ce0),
    .WE0  (we0),
    .WEM0 (wem0),
    .A0   (a0),
    .D0   (d0),
    .CE1  (ce1),
    .A1   (a1),
    .Q1   (q1)
  );
endmodule
